rv32im_divider: RTL and testbench

//  Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU; sits between operand read and register writeback.

---
 rtl/rv32im_divider.sv | 141 ++++++++++++++
 tb/tb_rv32im_divider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one result per XLEN steps.
// Define RV32IM_DIV_FASTPATH_EN to retire divide-by-zero and signed overflow after a single step.
module rv32im_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] val_rs1_i,
    input  logic [XLEN-1:0] val_rs2_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic            we_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] val_rd_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q, res_q;
    logic            neg_quo_q, neg_rem_q, is_rem_q, busy_q, we_q;
    logic [4:0]      rd_pend_q, rd_q;

    logic            is_signed_d, s1_d, s2_d, accept_d, last_d;
    logic [XLEN-1:0] abs1_d, abs2_d, quo_d, rem_d, res_d;
    logic [XLEN:0]   trial_d;

`ifdef RV32IM_DIV_FASTPATH_EN
    logic            fast_q, fast_d;
    logic [XLEN-1:0] fast_res_q, fast_res_d;

    assign fast_d = (val_rs2_i == '0) ||
                    (is_signed_d && (val_rs1_i == MIN_NEG) && (val_rs2_i == '1));
    always_comb begin
        if (val_rs2_i == '0) fast_res_d = op_i[1] ? val_rs1_i : '1;
        else                 fast_res_d = op_i[1] ? '0 : MIN_NEG;
    end
`endif

    // |x| of the most negative value wraps to itself, which is its correct unsigned magnitude
    assign is_signed_d = ~op_i[0];
    assign s1_d        = is_signed_d & val_rs1_i[XLEN-1];
    assign s2_d        = is_signed_d & val_rs2_i[XLEN-1];
    assign abs1_d      = s1_d ? -val_rs1_i : val_rs1_i;
    assign abs2_d      = s2_d ? -val_rs2_i : val_rs2_i;
    assign accept_d    = (state_q != CALC) && start_i && !kill_i;

    always_comb begin
        trial_d = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        if (trial_d[XLEN]) rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        else               rem_d = trial_d[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ~trial_d[XLEN]};
        if (is_rem_q) res_d = neg_rem_q ? -rem_d : rem_d;
        else          res_d = neg_quo_q ? -quo_d : quo_d;
        last_d = (cnt_q == CW'(XLEN-1));
`ifdef RV32IM_DIV_FASTPATH_EN
        if (fast_q) begin
            res_d  = fast_res_q;
            last_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            rd_pend_q <= '0;
            rd_q      <= '0;
`ifdef RV32IM_DIV_FASTPATH_EN
            fast_q     <= 1'b0;
            fast_res_q <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            if (kill_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        state_q <= IDLE;
                        if (accept_d) begin
                            state_q   <= CALC;
                            busy_q    <= 1'b1;
                            cnt_q     <= '0;
                            quo_q     <= abs1_d;
                            rem_q     <= '0;
                            dvs_q     <= abs2_d;
                            is_rem_q  <= op_i[1];
                            neg_rem_q <= s1_d;
                            // a zero divisor yields all ones regardless of dividend sign
                            neg_quo_q <= (s1_d ^ s2_d) && (val_rs2_i != '0);
                            rd_pend_q <= rd_addr_i;
`ifdef RV32IM_DIV_FASTPATH_EN
                            fast_q     <= fast_d;
                            fast_res_q <= fast_res_d;
`endif
                        end
                    end
                    CALC: begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            we_q    <= 1'b1;
                            rd_q    <= rd_pend_q;
                            res_q   <= res_d;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o    = busy_q;
    assign we_o      = we_q;
    assign rd_addr_o = rd_q;
    assign val_rd_o  = res_q;
endmodule

// File: tb/tb_rv32im_divider.sv
// Scoreboard bench for rv32im_divider: directed vectors, handshake, kill and reset cases.
module tb_rv32im_divider;
`ifdef RV32IM_DIV_FASTPATH_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, kill;
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd;
    logic        busy, we;
    logic [4:0]  rd_out;
    logic [31:0] val_out;

    always #5 clk = ~clk;

    rv32im_divider #(.XLEN(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .kill_i(kill), .op_i(op),
        .val_rs1_i(rs1), .val_rs2_i(rs2), .rd_addr_i(rd),
        .busy_o(busy), .we_o(we), .rd_addr_o(rd_out), .val_rd_o(val_out)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        int          due;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic [31:0] last_val;
    logic [4:0]  last_rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: every writeback strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && we !== 1'b0) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_we: got rd=%0d val=%h expected no writeback", rd_out, val_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, "_val"}, val_out, e.val);
                chk({e.nm, "_rd"}, {27'd0, rd_out}, {27'd0, e.rd});
                chk({e.nm, "_lat"}, cyc, e.due);
            end
        end
    end

    task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] expv, input bit fast, input bit push);
        int lat;
        lat   = (FAST_EN && fast) ? 1 : 32;
        op    = o;
        rs1   = a;
        rs2   = b;
        rd    = r;
        start = 1'b1;
        if (push) begin
            sb.push_back('{r, expv, cyc + 1 + lat, nm});
            last_val = expv;
            last_rd  = r;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_quiet(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && busy === 1'b0 && we === 1'b0) done = 1'b1;
        end
        chk({nm, "_drain"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_vec(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] r, input logic [31:0] expv, input bit fast);
        issue(nm, o, a, b, r, expv, fast, 1'b1);
        wait_quiet(nm);
        chk({nm, "_hold"}, val_out, expv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0; rd = '0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        chk("rst_val", val_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec("div_100_7",    2'b00, 32'd100,      32'd7,        5'd5,  32'd14,       1'b0);
        run_vec("rem_100_7",    2'b10, 32'd100,      32'd7,        5'd6,  32'd2,        1'b0);
        run_vec("div_m100_7",   2'b00, 32'hFFFFFF9C, 32'd7,        5'd7,  32'hFFFFFFF2, 1'b0);
        run_vec("rem_m100_7",   2'b10, 32'hFFFFFF9C, 32'd7,        5'd8,  32'hFFFFFFFE, 1'b0);
        run_vec("divu_big_7",   2'b01, 32'hFFFFFF9C, 32'd7,        5'd9,  32'h24924916, 1'b0);
        run_vec("remu_big_7",   2'b11, 32'hFFFFFF9C, 32'd7,        5'd10, 32'd2,        1'b0);
        run_vec("divu_by0",     2'b01, 32'h1234,     32'd0,        5'd11, 32'hFFFFFFFF, 1'b1);
        run_vec("remu_by0",     2'b11, 32'h1234,     32'd0,        5'd12, 32'h1234,     1'b1);
        run_vec("div_neg_by0",  2'b00, 32'hFFFFFFFB, 32'd0,        5'd13, 32'hFFFFFFFF, 1'b1);
        run_vec("rem_neg_by0",  2'b10, 32'hFFFFFFFB, 32'd0,        5'd14, 32'hFFFFFFFB, 1'b1);
        run_vec("div_ovf",      2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b1);
        run_vec("rem_ovf",      2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1'b1);
        run_vec("div_7_m2",     2'b00, 32'd7,        32'hFFFFFFFE, 5'd17, 32'hFFFFFFFD, 1'b0);
        run_vec("rem_7_m2",     2'b10, 32'd7,        32'hFFFFFFFE, 5'd18, 32'd1,        1'b0);
        run_vec("div_m7_m2",    2'b00, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd19, 32'd3,        1'b0);
        run_vec("rem_m7_m2",    2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd20, 32'hFFFFFFFF, 1'b0);
        run_vec("divu_min_1",   2'b01, 32'h80000000, 32'd1,        5'd21, 32'h80000000, 1'b0);
        run_vec("div_min_1",    2'b00, 32'h80000000, 32'd1,        5'd23, 32'h80000000, 1'b0);
        run_vec("divu_max_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd22, 32'd1,        1'b0);
        run_vec("divu_rd0",     2'b01, 32'd10,       32'd3,        5'd0,  32'd3,        1'b0);

        // back-to-back: second start lands in the writeback cycle of the first
        begin
            bit seen;
            issue("b2b_first", 2'b00, 32'd100, 32'd7, 5'd1, 32'd14, 1'b0, 1'b1);
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                if (we === 1'b1) seen = 1'b1;
                else @(negedge clk);
            end
            chk("b2b_we_seen", {31'd0, seen}, 32'd1);
            issue("b2b_second", 2'b10, 32'd100, 32'd7, 5'd2, 32'd2, 1'b0, 1'b1);
            chk("b2b_busy", {31'd0, busy}, 32'd1);
            wait_quiet("b2b");
        end

        // kill mid-calculation, then a fresh operation
        issue("kill_op", 2'b01, 32'd1000, 32'd3, 5'd4, 32'd0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        chk("kill_we", {31'd0, we}, 32'd0);
        repeat (40) @(negedge clk);
        run_vec("after_kill", 2'b01, 32'd1000, 32'd3, 5'd4, 32'd333, 1'b0);

        // kill beats a simultaneous start
        op = 2'b01; rs1 = 32'd9; rs2 = 32'd3; rd = 5'd3; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("kill_vs_start_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);

        // start during calculation is ignored
        issue("ignore_start", 2'b00, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        op = 2'b01; rs1 = 32'd9; rs2 = 32'd3; rd = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_quiet("ignore_start");
        chk("ignore_start_rd_hold", {27'd0, rd_out}, {27'd0, last_rd});

        // asynchronous reset mid-calculation clears outputs immediately
        issue("rst_op", 2'b01, 32'd50, 32'd5, 5'd3, 32'd0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_we", {31'd0, we}, 32'd0);
        chk("arst_rd", {27'd0, rd_out}, 32'd0);
        chk("arst_val", val_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec("after_rst", 2'b00, 32'hFFFFFF9C, 32'd7, 5'd25, 32'hFFFFFFF2, 1'b0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
